// File: rtl/mux4_scan_sampler.sv
// Scans a NOR-built 4:1 mux by stepping its select lines and sampling the mux
// output after a settle delay, presenting the four samples as one word.

module mux4_nor (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   input  logic s0,
   input  logic s1,
   output logic w
);

   logic term_a;
   logic term_b;
   logic term_c;
   logic term_d;
   logic none_selected;

   // Each product term is a NOR of the select pattern it rejects and the inverted data.
   assign term_a = ~(s1 | s0 | ~a);
   assign term_b = ~(s1 | ~s0 | ~b);
   assign term_c = ~(~s1 | s0 | ~c);
   assign term_d = ~(~s1 | ~s0 | ~d);

   assign none_selected = ~(term_a | term_b | term_c | term_d);
   assign w = ~none_selected;

endmodule

module mux4_scan_sampler #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       w,
   input  logic       ack,
   output logic       s0,
   output logic       s1,
   output logic [3:0] data_out,
   output logic       valid,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_COUNT = 4'(SETTLE - 1);

   state_t     state;
   logic [1:0] channel;
   logic [3:0] settle_count;
   logic [3:0] cap_buf;
   logic [3:0] captured;

   // Buffer as it will look after this edge's capture, so the final channel's
   // bit lands in data_out on the same edge it is sampled.
   always_comb begin
      captured          = cap_buf;
      captured[channel] = w;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         channel      <= 2'd0;
         settle_count <= 4'd0;
         cap_buf      <= 4'd0;
         data_out     <= 4'd0;
         valid        <= 1'b0;
         busy         <= 1'b0;
         s0           <= 1'b0;
         s1           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= SCAN;
                  channel      <= 2'd0;
                  settle_count <= 4'd0;
                  busy         <= 1'b1;
                  {s1, s0}     <= 2'd0;
               end
            end

            SCAN: begin
               if (settle_count == LAST_COUNT) begin
                  settle_count <= 4'd0;
                  cap_buf      <= captured;
                  if (channel == 2'd3) begin
                     state    <= DONE;
                     data_out <= captured;
                     valid    <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     channel  <= channel + 2'd1;
                     {s1, s0} <= channel + 2'd1;
                  end
               end else begin
                  settle_count <= settle_count + 4'd1;
               end
            end

            DONE: begin
               // Select stays parked on channel 3 until the word is taken.
               if (ack) begin
                  valid        <= 1'b0;
                  channel      <= 2'd0;
                  settle_count <= 4'd0;
                  {s1, s0}     <= 2'd0;
                  if (start) begin
                     state <= SCAN;
                     busy  <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               channel  <= 2'd0;
               valid    <= 1'b0;
               busy     <= 1'b0;
               {s1, s0} <= 2'd0;
            end
         endcase
      end
   end

endmodule
